rate_ctrl: RTL

- Rate controller for the push-button-throttled slow clock.
- Accepts debounced up/down button levels and keeps a saturating preset index 0..5.
- Maps the index to a half-period terminal count and runs the divide counter.
- Rate changes are committed only at half-period boundaries, so slow_clk never produces a runt pulse. It sits between the debouncers and the consumers of slow_clk and freq_num.

---
 rtl/rate_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rate_ctrl.sv
// rate_ctrl: push-button-throttled slow clock generator.
// Keeps a saturating preset index 0..5 from debounced up/down levels and
// commits rate changes only at half-period boundaries, so slow_clk never runts.
// Optional build macro RATE_CTRL_AUTO_SWEEP_EN adds a ping-pong auto-sweep
// driven by sweep_en; without it sweep_en is ignored.
module rate_ctrl #(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned P0        = 12500000,
    parameter int unsigned P1        = 6250000,
    parameter int unsigned P2        = 4166666,
    parameter int unsigned P3        = 3125000,
    parameter int unsigned P4        = 2500000,
    parameter int unsigned P5        = 2083333,
    parameter int unsigned RESET_IDX = 0,
    parameter int unsigned DWELL     = 4
) (
    input  logic       CLK_50,
    input  logic       reset,
    input  logic       up_lvl,
    input  logic       dn_lvl,
    input  logic       sweep_en,
    output logic       slow_clk,
    output logic       tick,
    output logic [2:0] freq_num,
    output logic       pending
);

    // Terminal counts may equal 2^CNT_W, so they need one extra bit.
    localparam int unsigned TC_W    = CNT_W + 1;
    localparam logic [2:0]  IDX_MAX = 3'd5;
    localparam logic [2:0]  IDX_RST = 3'(RESET_IDX);

    function automatic logic [TC_W-1:0] preset(input logic [2:0] idx);
        case (idx)
            3'd0:    preset = TC_W'(P0);
            3'd1:    preset = TC_W'(P1);
            3'd2:    preset = TC_W'(P2);
            3'd3:    preset = TC_W'(P3);
            3'd4:    preset = TC_W'(P4);
            default: preset = TC_W'(P5);
        endcase
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [TC_W-1:0]  tc_active;
    logic [2:0]       req_idx;
    logic [2:0]       man_nxt;
    logic [2:0]       req_nxt;
    logic             up_prv;
    logic             dn_prv;
    logic             up_rise;
    logic             dn_rise;
    logic             boundary;

    // Button edge detect and half-period boundary decode.
    always_comb begin
        up_rise  = up_lvl & ~up_prv;
        dn_rise  = dn_lvl & ~dn_prv;
        boundary = (TC_W'(cnt) == (tc_active - TC_W'(1)));
    end

    // Manual request: saturating step, simultaneous up/down cancel.
    always_comb begin
        man_nxt = req_idx;
        if (up_rise && !dn_rise && (req_idx != IDX_MAX)) begin
            man_nxt = req_idx + 3'd1;
        end else if (dn_rise && !up_rise && (req_idx != 3'd0)) begin
            man_nxt = req_idx - 3'd1;
        end
    end

`ifdef RATE_CTRL_AUTO_SWEEP_EN
    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [DW_W-1:0] dwell_cnt;
    logic [DW_W-1:0] dwell_nxt;
    logic            dir_up;
    logic            dir_nxt;
    logic            sweep_step;

    // Sweep: count ticks while enabled; manual edges override and restart the dwell.
    always_comb begin
        req_nxt    = man_nxt;
        dwell_nxt  = dwell_cnt;
        dir_nxt    = dir_up;
        sweep_step = 1'b0;
        if (!sweep_en || up_rise || dn_rise) begin
            dwell_nxt = '0;
        end else if (tick) begin
            if (dwell_cnt == DW_W'(DWELL - 1)) begin
                dwell_nxt  = '0;
                sweep_step = 1'b1;
            end else begin
                dwell_nxt = dwell_cnt + DW_W'(1);
            end
        end
        if (sweep_step) begin
            if ((dir_up && (req_idx != IDX_MAX)) || (req_idx == 3'd0)) begin
                req_nxt = req_idx + 3'd1;
                dir_nxt = ((req_idx + 3'd1) != IDX_MAX);
            end else begin
                req_nxt = req_idx - 3'd1;
                dir_nxt = ((req_idx - 3'd1) == 3'd0);
            end
        end
    end

    // Sweep state registers; direction restarts upward on reset.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            dwell_cnt <= '0;
            dir_up    <= 1'b1;
        end else begin
            dwell_cnt <= dwell_nxt;
            dir_up    <= dir_nxt;
        end
    end
`else
    localparam int unsigned dwell_unused = DWELL;
    logic sweep_en_unused;

    // Without the sweep build the request follows the buttons only.
    always_comb begin
        req_nxt         = man_nxt;
        sweep_en_unused = sweep_en;
    end
`endif

    // Divider, commit of requested rate at boundaries, and button history.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            cnt       <= '0;
            slow_clk  <= 1'b0;
            tick      <= 1'b0;
            freq_num  <= IDX_RST;
            req_idx   <= IDX_RST;
            tc_active <= preset(IDX_RST);
            up_prv    <= up_lvl;
            dn_prv    <= dn_lvl;
        end else begin
            up_prv  <= up_lvl;
            dn_prv  <= dn_lvl;
            req_idx <= req_nxt;
            if (boundary) begin
                cnt       <= '0;
                slow_clk  <= ~slow_clk;
                tick      <= ~slow_clk;
                tc_active <= preset(req_idx);
                freq_num  <= req_idx;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end
    end

    assign pending = (req_idx != freq_num);

endmodule
